// File: rtl/citadel_bridge_pkg.sv
// Shared opcodes, response codes, state encoding and byte helpers for the
// byte-stream-to-memory-bus bridge.
package citadel_bridge_pkg;

    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } bridge_state_t;

    // Replace byte lane idx of a little-endian word with a new byte.
    function automatic logic [31:0] byte_insert(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [31:0] w_word;
        w_word = word;
        w_word[{idx, 3'b000} +: 8] = data;
        return w_word;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_bridge_master_if.sv
// Command/response byte streams, native memory bus and status for the bridge.
interface mem_bridge_master_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        bus_err;

    modport master (
        input  in_data, in_valid, out_ready, mem_ready, mem_rdata,
        output in_ready, out_data, out_valid, mem_valid, mem_addr,
               mem_wdata, mem_wstrb, busy, bus_err
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_ready, mem_rdata,
        input  in_ready, out_data, out_valid, mem_valid, mem_addr,
               mem_wdata, mem_wstrb, busy, bus_err
    );
endinterface

// File: rtl/mem_bridge_master.sv
// Decodes ping/read/write byte commands into single-word memory bus accesses
// and streams ACK/NAK or read-data bytes back out.
module mem_bridge_master
    import citadel_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    mem_bridge_master_if.master bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t    r_state;
    logic [1:0]       r_idx;
    logic             r_is_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [23:0]      r_rsp;
    logic             r_rsp_multi;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic        w_in_fire;
    logic        w_out_fire;
    logic [31:0] w_addr_ins;
    logic [31:0] w_wdata_ins;

    assign w_in_fire   = bus.in_valid && bus.in_ready;
    assign w_out_fire  = bus.out_valid && bus.out_ready;
    assign w_addr_ins  = byte_insert(r_addr, r_idx, bus.in_data);
    assign w_wdata_ins = byte_insert(r_wdata, r_idx, bus.in_data);

    // Command decode, bus access with timeout, and response streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_is_write    <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_rsp         <= 24'd0;
            r_rsp_multi   <= 1'b0;
            r_tmo_cnt     <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_data  <= 8'd0;
            bus.out_valid <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'b0000;
            bus.busy      <= 1'b0;
            bus.bus_err   <= 1'b0;
        end else begin
            bus.bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        bus.busy <= 1'b1;
                        r_idx    <= 2'd0;
                        case (bus.in_data)
                            OP_READ, OP_WRITE: begin
                                r_is_write <= (bus.in_data == OP_WRITE);
                                r_state    <= ST_ADDR;
                            end
                            default: begin
                                bus.out_data  <= (bus.in_data == OP_PING) ? RSP_ACK : RSP_NAK;
                                bus.out_valid <= 1'b1;
                                bus.in_ready  <= 1'b0;
                                r_rsp_multi   <= 1'b0;
                                r_state       <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_in_fire) begin
                        r_addr <= w_addr_ins;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= ST_DATA;
                            end else begin
                                bus.in_ready  <= 1'b0;
                                bus.mem_valid <= 1'b1;
                                bus.mem_addr  <= word_align(w_addr_ins);
                                bus.mem_wstrb <= 4'b0000;
                                r_tmo_cnt     <= '0;
                                r_state       <= ST_BUS;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_in_fire) begin
                        r_wdata <= w_wdata_ins;
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            bus.in_ready  <= 1'b0;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= word_align(r_addr);
                            bus.mem_wdata <= w_wdata_ins;
                            bus.mem_wstrb <= 4'b1111;
                            r_tmo_cnt     <= '0;
                            r_state       <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Ready beats the timeout when both land on the same cycle.
                    if (bus.mem_valid && bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.out_valid <= 1'b1;
                        r_tmo_cnt     <= '0;
                        r_idx         <= 2'd0;
                        r_state       <= ST_RESP;
                        if (r_is_write) begin
                            bus.out_data <= RSP_ACK;
                            r_rsp_multi  <= 1'b0;
                        end else begin
                            bus.out_data <= bus.mem_rdata[7:0];
                            r_rsp        <= bus.mem_rdata[31:8];
                            r_rsp_multi  <= 1'b1;
                        end
                    end else if (bus.mem_valid && (r_tmo_cnt >= TMO_LAST)) begin
                        bus.mem_valid <= 1'b0;
                        bus.bus_err   <= 1'b1;
                        bus.out_data  <= RSP_NAK;
                        bus.out_valid <= 1'b1;
                        r_rsp_multi   <= 1'b0;
                        r_idx         <= 2'd0;
                        r_state       <= ST_RESP;
                    end else if (bus.mem_valid) begin
                        r_tmo_cnt <= r_tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt;
                    end
                end
                ST_RESP: begin
                    if (w_out_fire) begin
                        if (!r_rsp_multi || (r_idx == 2'd3)) begin
                            bus.out_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            bus.busy      <= 1'b0;
                            r_idx         <= 2'd0;
                            r_state       <= ST_IDLE;
                        end else begin
                            bus.out_data <= r_rsp[7:0];
                            r_rsp        <= {8'd0, r_rsp[23:8]};
                            r_idx        <= r_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    bus.mem_valid <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge_master.sv
// Directed bench for mem_bridge_master: a queue-based model of the command
// protocol predicts bus transactions and response bytes, checked every cycle.
module tb_mem_bridge_master;
    import citadel_bridge_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bridge_master_if bus();
    mem_bridge_master #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    txn_t       exp_txn[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] got_rsp[$];

    bit          resp_never = 1'b0;
    int          resp_delay = 1;
    int          resp_wait  = 0;
    logic [31:0] resp_rdata = 32'd0;

    int          vh_cnt = 0, vh_len = 0, mv_rises = 0, err_pulses = 0;
    logic        prev_mv = 1'b0, prev_hit = 1'b0, prev_stall = 1'b0;
    logic [7:0]  prev_od = 8'd0;
    logic [31:0] prev_addr = 32'd0;
    logic [3:0]  prev_strb = 4'd0;
    txn_t        last_txn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=<nothing expected>", name, act);
    endtask

    // Memory responder: ready pulse resp_delay cycles after valid, dropped next cycle.
    always @(posedge clk) begin
        #1;
        if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            resp_wait     = 0;
        end else if (bus.mem_valid && !resp_never) begin
            resp_wait++;
            if (resp_wait >= resp_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = resp_rdata;
                resp_wait     = 0;
            end
        end else begin
            resp_wait = 0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            prev_mv = 1'b0; prev_hit = 1'b0; prev_stall = 1'b0; vh_cnt = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got_rsp.push_back(bus.out_data);
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected", {24'd0, bus.out_data});
                else chk("rsp_byte", {24'd0, bus.out_data}, {24'd0, exp_rsp.pop_front()});
            end
            if (prev_hit) chk("rsp_latency", {31'd0, bus.out_valid}, 32'd1);
            if (prev_stall) chk("stall_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, prev_od});
            if (bus.out_valid || bus.mem_valid) begin
                chk("in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                chk("busy_high", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.mem_valid && !prev_mv) begin
                mv_rises++;
                last_txn = '{bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
                if (exp_txn.size() == 0) fail_now("txn_unexpected", bus.mem_addr);
                else begin
                    txn_t t;
                    t = exp_txn.pop_front();
                    chk("txn_addr", bus.mem_addr, t.addr);
                    chk("txn_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, t.wstrb});
                    if (t.wstrb == 4'hF) chk("txn_wdata", bus.mem_wdata, t.wdata);
                end
            end
            if (bus.mem_valid && prev_mv) begin
                chk("addr_stable", bus.mem_addr, prev_addr);
                chk("wstrb_stable", {28'd0, bus.mem_wstrb}, {28'd0, prev_strb});
            end
            if (bus.mem_valid) vh_cnt++;
            else if (prev_mv) begin vh_len = vh_cnt; vh_cnt = 0; end
            if (bus.bus_err) err_pulses++;
            prev_hit   = bus.mem_valid && bus.mem_ready;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_od    = bus.out_data;
            prev_mv    = bus.mem_valid;
            prev_addr  = bus.mem_addr;
            prev_strb  = bus.mem_wstrb;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("in_ready_timeout", {24'd0, b});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        bit is_mem;
        is_mem = (op == 8'h52) || (op == 8'h57);
        if (op == 8'h50) exp_rsp.push_back(8'h06);
        else if (is_mem) begin
            t.addr  = addr & 32'hFFFF_FFFC;
            t.wdata = data;
            t.wstrb = (op == 8'h57) ? 4'hF : 4'h0;
            exp_txn.push_back(t);
            if (resp_never) exp_rsp.push_back(8'h15);
            else if (op == 8'h57) exp_rsp.push_back(8'h06);
            else for (int k = 0; k < 4; k++) exp_rsp.push_back(resp_rdata[8*k +: 8]);
        end else exp_rsp.push_back(8'h15);
        send_byte(op);
        if (is_mem) for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
        if (op == 8'h57) for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8]);
        @(negedge clk);
        if (is_mem) chk("lat_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
        else        chk("lat_rsp_valid", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_rsp.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, e0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b1;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_outs", {bus.out_valid, bus.out_data, bus.mem_valid, bus.mem_wstrb, bus.busy, bus.bus_err},
            32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Ping: single ACK, no bus traffic.
        got_rsp.delete(); m0 = mv_rises;
        run_cmd(8'h50, 32'd0, 32'd0);
        wait_done("ping_done");
        chk("ping_byte", {24'd0, got_rsp[0]}, 32'h06);
        chk("ping_no_bus", mv_rises, m0);
        chk("ping_busy", {31'd0, bus.busy}, 32'd0);

        // Write with ready one cycle after valid.
        got_rsp.delete(); resp_delay = 1;
        run_cmd(8'h57, 32'h1234_5678, 32'hDEAD_BEEF);
        wait_done("write_done");
        chk("wr_addr", last_txn.addr, 32'h1234_5678);
        chk("wr_data", last_txn.wdata, 32'hDEAD_BEEF);
        chk("wr_strb", {28'd0, last_txn.wstrb}, 32'hF);
        chk("wr_rsp", {24'd0, got_rsp[0]}, 32'h06);

        // Read returns rdata LSB first.
        got_rsp.delete(); resp_delay = 3; resp_rdata = 32'hCAFE_F00D;
        run_cmd(8'h52, 32'h0000_0100, 32'd0);
        wait_done("read_done");
        chk("rd_addr", last_txn.addr, 32'h0000_0100);
        chk("rd_strb", {28'd0, last_txn.wstrb}, 32'h0);
        chk("rd_count", got_rsp.size(), 32'd4);
        chk("rd_bytes", {got_rsp[3], got_rsp[2], got_rsp[1], got_rsp[0]}, 32'hCAFE_F00D);

        // Timeout: no ready ever.
        got_rsp.delete(); resp_never = 1'b1; e0 = err_pulses;
        run_cmd(8'h52, 32'h0000_4000, 32'd0);
        wait_done("tmo_done");
        chk("tmo_valid_len", vh_len, 32'd8);
        chk("tmo_err_pulses", err_pulses - e0, 32'd1);
        chk("tmo_rsp", {24'd0, got_rsp[0]}, 32'h15);
        resp_never = 1'b0;

        // Unknown opcode.
        got_rsp.delete();
        run_cmd(8'h41, 32'd0, 32'd0);
        wait_done("unk_done");
        chk("unk_rsp", {24'd0, got_rsp[0]}, 32'h15);

        // Stalled consumer during a read response.
        got_rsp.delete(); resp_delay = 2; resp_rdata = 32'h1122_3344; bus.out_ready = 1'b0;
        run_cmd(8'h52, 32'h0000_0203, 32'd0);
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_first", {24'd0, bus.out_data}, 32'h44);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_done("stall_done");
        chk("stall_bytes", {got_rsp[3], got_rsp[2], got_rsp[1], got_rsp[0]}, 32'h1122_3344);
        chk("stall_addr", last_txn.addr, 32'h0000_0200);

        // Unaligned write address is word aligned on the bus.
        got_rsp.delete(); resp_delay = 1;
        run_cmd(8'h57, 32'h0000_0ABE, 32'h0102_0304);
        wait_done("wr2_done");
        chk("wr2_addr", last_txn.addr, 32'h0000_0ABC);

        // Asynchronous reset during an outstanding bus request.
        resp_never = 1'b1;
        run_cmd(8'h52, 32'h0000_0300, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        exp_rsp.delete(); exp_txn.delete();
        resp_never = 1'b0;
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        got_rsp.delete();
        run_cmd(8'h50, 32'd0, 32'd0);
        wait_done("post_rst_done");
        chk("post_rst_ping", {24'd0, got_rsp[0]}, 32'h06);

        chk("model_drained", exp_rsp.size() + exp_txn.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
